score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL expose parameter WIN_SCORE, default 7, points needed to win the match (legal range 1..15).
REQ-002 SHALL expose parameter PAUSE_FRAMES, default 90, frame ticks of freeze after each non-final point (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port frame_tick, input, 1, raw 60 Hz one-cycle enable.
REQ-006 SHALL have port start_btn, input, 1, level from a synchronised, debounced button.
REQ-007 SHALL have port valid, input, 1, physics one-cycle strobe: game_over and winner are meaningful this cycle.
REQ-008 SHALL have port game_over, input, 1, physics point-ended flag.
REQ-009 SHALL have port winner, input, 2, physics point winner: 1 = P1, 2 = P2, others are invalid.
REQ-010 SHALL have port phys_en, output, 1, gated enable to the physics engine.
REQ-011 SHALL have port p1_score / p2_score, output, 4 each, current points.
REQ-012 SHALL have port state, output, 2, encoding IDLE=0, PLAY=1, PAUSE=2, OVER=3.
REQ-013 SHALL have port match_winner, output, 2, 0 = none, 1 = P1, 2 = P2.
REQ-014 SHALL have port point_pulse, output, 1, one-cycle pulse on each accepted point.

Function
REQ-015 phys_en SHALL equal frame_tick AND (state==PLAY), combinational, zero latency.
REQ-016 start_btn SHALL be edge-detected: press = current 1 AND previous-cycle 1'b0; the previous register updates every clk.
REQ-017 Point-accept condition SHALL be: state==PLAY AND valid AND game_over AND go_prev==0 AND winner in {1,2}.
REQ-018 go_prev SHALL load game_over only on cycles where valid=1, and SHALL hold otherwise.
REQ-019 An accepted point SHALL do all of the following on the same edge:
  - increment the winner's score by 1;
  - assert point_pulse on the next cycle, for exactly 1 cycle.
REQ-020 Point to a non-final score: if the incremented score < WIN_SCORE, SHALL go PLAY->PAUSE and load pause_cnt = PAUSE_FRAMES.
REQ-021 Point to the final score: if the incremented score == WIN_SCORE, SHALL go PLAY->OVER and set match_winner = winner.
REQ-022 Pause count: in PAUSE, each frame_tick SHALL decrement pause_cnt; a tick seen with pause_cnt==1 SHALL go to PLAY.
REQ-023 IDLE: a start press SHALL go to PLAY with scores unchanged (0).
REQ-024 OVER: a start press SHALL go to PLAY with the following cleared on the same edge:
  - p1_score and p2_score set to 0;
  - match_winner set to 0.
REQ-025 Start presses in PLAY or PAUSE SHALL be ignored.
REQ-026 Points arriving in PAUSE, IDLE or OVER SHALL be ignored.
REQ-027 winner of 0 or 3 with game_over=1 SHALL be ignored, with no score change and no state change; go_prev still updates.
REQ-028 Scores SHALL never exceed WIN_SCORE, and SHALL never wrap.
REQ-029 A frame_tick in the same cycle as an accepted point SHALL still pass to phys_en, because the state is still PLAY in that cycle.

Reset
REQ-030 On rst_n low, immediately and regardless of clk:
  - state=IDLE;
  - p1_score=0, p2_score=0;
  - match_winner=0, point_pulse=0;
  - pause_cnt=0;
  - go_prev=0;
  - start-edge register=0.
REQ-031 Reset asserted mid-PAUSE or mid-OVER SHALL abort immediately with no residual counts; phys_en SHALL be 0 while in reset.

Verification
REQ-032 Reset then start press -> state=1; phys_en follows frame_tick; scores 0/0.
REQ-033 In PLAY, valid with game_over=1 and winner=2 -> p2_score=1, single point_pulse, state=2, phys_en low for exactly 90 ticks, then state=1.
REQ-034 game_over held high across 3 valid strobes -> exactly one point counted.
REQ-035 P1 reaches 7 -> state=3, match_winner=1, phys_en=0. Start press -> scores 0/0, match_winner=0, state=1.
REQ-036 Error and ignore cases:
  - winner=3 with game_over=1 -> no change;
  - start press during PAUSE -> ignored;
  - rst_n low during PAUSE -> all outputs reset values at once.

Source files
------------

// File: rtl/score_keeper.sv
// Match scoring controller: accepts point results from the physics engine,
// freezes play between points and declares the match winner.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       valid,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       phys_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic [1:0] match_winner,
  output logic       point_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [4:0] WIN_SCORE_W    = 5'(WIN_SCORE);
  localparam logic [7:0] PAUSE_FRAMES_W = 8'(PAUSE_FRAMES);

  state_e     state_q, state_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic [1:0] match_winner_q, match_winner_d;
  logic       point_pulse_q, point_pulse_d;
  logic [7:0] pause_cnt_q, pause_cnt_d;
  logic       go_prev_q, go_prev_d;
  logic       start_prev_q, start_prev_d;

  logic       start_press;
  logic       winner_ok;
  logic       point_accept;
  logic [4:0] p1_inc;
  logic [4:0] p2_inc;
  logic [4:0] win_inc;

  assign start_press  = start_btn & ~start_prev_q;
  assign winner_ok    = (winner == 2'd1) || (winner == 2'd2);
  // go_prev blocks a game_over level held across several valid strobes
  assign point_accept = (state_q == PLAY) & valid & game_over & ~go_prev_q & winner_ok;

  assign p1_inc  = {1'b0, p1_score_q} + 5'd1;
  assign p2_inc  = {1'b0, p2_score_q} + 5'd1;
  assign win_inc = (winner == 2'd1) ? p1_inc : p2_inc;

  always_comb begin
    start_prev_d   = start_btn;
    go_prev_d      = valid ? game_over : go_prev_q;
    point_pulse_d  = point_accept;
    state_d        = state_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    match_winner_d = match_winner_q;
    pause_cnt_d    = pause_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (point_accept) begin
          // Saturating guard keeps scores at or below WIN_SCORE
          if (winner == 2'd1 && p1_inc <= WIN_SCORE_W) begin
            p1_score_d = p1_inc[3:0];
          end else if (winner == 2'd2 && p2_inc <= WIN_SCORE_W) begin
            p2_score_d = p2_inc[3:0];
          end
          if (win_inc >= WIN_SCORE_W) begin
            state_d        = OVER;
            match_winner_d = winner;
          end else begin
            state_d     = PAUSE;
            pause_cnt_d = PAUSE_FRAMES_W;
          end
        end
      end

      PAUSE: begin
        if (frame_tick) begin
          if (pause_cnt_q <= 8'd1) begin
            state_d     = PLAY;
            pause_cnt_d = 8'd0;
          end else begin
            pause_cnt_d = pause_cnt_q - 8'd1;
          end
        end
      end

      OVER: begin
        if (start_press) begin
          state_d        = PLAY;
          p1_score_d     = 4'd0;
          p2_score_d     = 4'd0;
          match_winner_d = 2'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      match_winner_q <= 2'd0;
      point_pulse_q  <= 1'b0;
      pause_cnt_q    <= 8'd0;
      go_prev_q      <= 1'b0;
      start_prev_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      match_winner_q <= match_winner_d;
      point_pulse_q  <= point_pulse_d;
      pause_cnt_q    <= pause_cnt_d;
      go_prev_q      <= go_prev_d;
      start_prev_q   <= start_prev_d;
    end
  end

  // Registered state is IDLE during reset, so phys_en is forced low there too
  assign phys_en      = frame_tick & (state_q == PLAY);
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign state        = state_q;
  assign match_winner = match_winner_q;
  assign point_pulse  = point_pulse_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with WIN_SCORE=7, PAUSE_FRAMES=90.
module tb_score_keeper;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       start_btn;
  logic       valid;
  logic       game_over;
  logic [1:0] winner;
  logic       phys_en;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] state;
  logic [1:0] match_winner;
  logic       point_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks;
  int phys_seen;
  int pulse_seen;

  score_keeper #(.WIN_SCORE(7), .PAUSE_FRAMES(90)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .valid        (valid),
    .game_over    (game_over),
    .winner       (winner),
    .phys_en      (phys_en),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .state        (state),
    .match_winner (match_winner),
    .point_pulse  (point_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic go, input logic [1:0] w,
                               input logic ft, input logic sb);
    valid      = v;
    game_over  = go;
    winner     = w;
    frame_tick = ft;
    start_btn  = sb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs frame ticks until PAUSE ends (bounded); optionally injects a point at tick 10
  task automatic runPause(input logic inject);
    ticks      = 0;
    phys_seen  = 0;
    pulse_seen = 0;
    while (state == 2'd2 && ticks < 300) begin
      if (inject && ticks == 10) applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
      else                       applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      #1;
      if (phys_en) phys_seen++;
      step();
      if (point_pulse) pulse_seen++;
      ticks++;
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    #2;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_p1", p1_score, 0);
    checkOutput("reset_p2", p2_score, 0);
    checkOutput("reset_winner", match_winner, 0);
    checkOutput("reset_pulse", point_pulse, 0);
    checkOutput("reset_phys_en", phys_en, 0);
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    checkOutput("idle_hold", state, 0);

    // Start press from IDLE; holding the button must not re-trigger
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    checkOutput("start_play", state, 1);
    step();
    checkOutput("start_held", state, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    #1;
    checkOutput("phys_en_tick", phys_en, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    checkOutput("phys_en_notick", phys_en, 0);
    checkOutput("play_scores", {p1_score, p2_score}, 0);

    // Invalid winner: nothing changes but go_prev is loaded
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    step();
    checkOutput("w3_state", state, 1);
    checkOutput("w3_scores", {p1_score, p2_score}, 0);
    checkOutput("w3_pulse", point_pulse, 0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    checkOutput("goprev_block_p2", p2_score, 0);
    checkOutput("goprev_block_state", state, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();

    // Point to P2 with a frame tick in the same cycle
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
    #1;
    checkOutput("phys_en_point_cycle", phys_en, 1);
    step();
    checkOutput("p2_point_score", p2_score, 1);
    checkOutput("p2_point_pulse", point_pulse, 1);
    checkOutput("p2_point_state", state, 2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    checkOutput("pulse_one_cycle", point_pulse, 0);

    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    checkOutput("start_in_pause", state, 2);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();

    runPause(1'b1);
    checkOutput("pause_ticks", ticks, 90);
    checkOutput("pause_phys_en", phys_seen, 0);
    checkOutput("pause_point_ignored", p1_score, 0);
    checkOutput("pause_pulse_ignored", pulse_seen, 0);
    checkOutput("pause_end_state", state, 1);

    // game_over held high across three strobes counts once
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    pulse_seen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
      step();
      if (point_pulse) pulse_seen++;
      applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      step();
      if (point_pulse) pulse_seen++;
    end
    checkOutput("held_go_pulses", pulse_seen, 1);
    checkOutput("held_go_p1", p1_score, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    runPause(1'b0);
    checkOutput("pause2_ticks", ticks, 90);

    // P1 runs to 7
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      if (k < 7) runPause(1'b0);
    end
    checkOutput("final_p1", p1_score, 7);
    checkOutput("final_p2", p2_score, 1);
    checkOutput("final_state", state, 3);
    checkOutput("final_winner", match_winner, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    #1;
    checkOutput("over_phys_en", phys_en, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    checkOutput("over_point_ignored", p2_score, 1);
    checkOutput("over_state_hold", state, 3);

    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    checkOutput("restart_state", state, 1);
    checkOutput("restart_scores", {p1_score, p2_score}, 0);
    checkOutput("restart_winner", match_winner, 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step();

    // Asynchronous reset part-way through a pause
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    step();
    checkOutput("rp_state", state, 2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rp_async_state", state, 0);
    checkOutput("rp_async_p2", p2_score, 0);
    checkOutput("rp_async_phys_en", phys_en, 0);
    checkOutput("rp_async_pulse", point_pulse, 0);
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    checkOutput("rp_restart", state, 1);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    step();
    checkOutput("rp_first_point", p1_score, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    runPause(1'b0);
    checkOutput("rp_full_pause", ticks, 90);
    checkOutput("rp_end_state", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
